// File: rtl/freq_monitor.sv
// freq_monitor
//   Measures the rising-to-rising period of a slow asynchronous clock (clk_in)
//   in clk_50MHz cycles, declares lock after LOCK_COUNT consecutive in-range
//   periods, and flags a fault on an out-of-range period or a missing clock.
//
// Ports
//   clk_50MHz     in   sole clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   clk_in        in   monitored clock (asynchronous)
//   enable        in   0 forces IDLE and clears status outputs
//   period[7:0]   out  last measured period (holds between updates)
//   period_valid  out  one-cycle pulse when period updates
//   locked        out  high while in LOCKED
//   fault         out  high while in FAULT
//   missing       out  fault cause is a timeout (only with fault)
module freq_monitor #(
    parameter int NOMINAL_PERIOD = 50,
    parameter int TOLERANCE      = 2,
    parameter int LOCK_COUNT     = 4,
    parameter int TIMEOUT        = 255
) (
    input  logic       clk_50MHz,
    input  logic       rst_n,
    input  logic       clk_in,
    input  logic       enable,
    output logic [7:0] period,
    output logic       period_valid,
    output logic       locked,
    output logic       fault,
    output logic       missing
);

    localparam int         LO_LIM = NOMINAL_PERIOD - TOLERANCE;
    localparam int         HI_LIM = NOMINAL_PERIOD + TOLERANCE;
    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);
    localparam logic [7:0] LOCK_N = 8'(LOCK_COUNT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_MEASURE,
        S_LOCKED,
        S_FAULT
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] sync_q;          // [0],[1] synchronizer, [2] history
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] good_q, good_d;
    logic [7:0] period_q, period_d;
    logic       pv_q, pv_d;
    logic       missing_q, missing_d;
    logic       locked_q, fault_q;

    logic       edge_det;
    logic       timeout;
    logic       in_range;
    logic [7:0] meas;
    logic [7:0] cnt_inc;
    int         meas_i;

    assign edge_det = sync_q[1] & ~sync_q[2];
    assign cnt_inc  = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
    // Measured period is the count plus the detection cycle itself.
    assign meas     = cnt_inc;
    assign meas_i   = int'(meas);
    assign in_range = (meas_i >= LO_LIM) && (meas_i <= HI_LIM);
    assign timeout  = (cnt_q >= TO_CNT);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_inc;
        good_d    = good_q;
        period_d  = period_q;
        pv_d      = 1'b0;
        missing_d = missing_q;
        if (!enable) begin
            state_d   = S_IDLE;
            cnt_d     = 8'd0;
            missing_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d   = S_ARM;
                    cnt_d     = 8'd0;
                    missing_d = 1'b0;
                end
                S_ARM: begin
                    // First edge only establishes the reference point.
                    if (edge_det) begin
                        state_d = S_MEASURE;
                        good_d  = 8'd0;
                        cnt_d   = 8'd0;
                    end else if (timeout) begin
                        state_d   = S_FAULT;
                        missing_d = 1'b1;
                    end
                end
                default: begin
                    // Edge beats a coincident timeout.
                    if (edge_det) begin
                        cnt_d    = 8'd0;
                        period_d = meas;
                        pv_d     = 1'b1;
                        case (state_q)
                            S_MEASURE: begin
                                if (in_range) begin
                                    good_d = good_q + 8'd1;
                                    if (good_q + 8'd1 >= LOCK_N)
                                        state_d = S_LOCKED;
                                end else begin
                                    good_d = 8'd0;
                                end
                            end
                            S_LOCKED: begin
                                if (!in_range) begin
                                    state_d   = S_FAULT;
                                    missing_d = 1'b0;
                                end
                            end
                            default: begin
                                // Recovery edge: reported but not counted.
                                state_d   = S_MEASURE;
                                good_d    = 8'd0;
                                missing_d = 1'b0;
                            end
                        endcase
                    end else if (timeout && state_q != S_FAULT) begin
                        state_d   = S_FAULT;
                        missing_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sync_q    <= 3'b000;
            cnt_q     <= 8'd0;
            good_q    <= 8'd0;
            period_q  <= 8'd0;
            pv_q      <= 1'b0;
            missing_q <= 1'b0;
            locked_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= {sync_q[1:0], clk_in};
            cnt_q     <= cnt_d;
            good_q    <= good_d;
            period_q  <= period_d;
            pv_q      <= pv_d;
            missing_q <= missing_d & (state_d == S_FAULT);
            locked_q  <= (state_d == S_LOCKED);
            fault_q   <= (state_d == S_FAULT);
        end
    end

    assign period       = period_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign fault        = fault_q;
    assign missing      = missing_q;

endmodule
